prefix_subtractor_pipe: RTL and testbench
=========================================

Name: prefix_subtractor_pipe

Overview:
- 2-stage pipelined W-bit subtractor computing D = X - Y. Produces a borrow-out and a signed-overflow flag.
- Counterpart to the team's parallel-prefix adder. It reuses the same generate/propagate prefix (Kogge-Stone style) structure, with the Y operand inverted and carry-in forced to 1.
- Sits between an operand source and a result sink. Both sides use valid/ready handshakes, and backpressure is supported at full throughput.

Parameters:
- W, 6, operand/result width in bits (legal 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair X/Y is valid
- in_ready  output  1  block accepts the operand pair this cycle
- X  input  W  minuend (unsigned / two's complement)
- Y  input  W  subtrahend
- out_valid  output  1  D/bout/ovf are valid
- out_ready  input  1  sink accepts the result this cycle
- D  output  W  difference X - Y mod 2^W
- bout  output  1  borrow out: 1 iff X < Y as unsigned (= NOT carry-out of X + ~Y + 1)
- ovf  output  1  signed overflow: X[W-1] != Y[W-1] and D[W-1] != X[W-1]

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - s1_valid = s2_valid = 0.
  - out_valid = 0, D = 0, bout = 0, ovf = 0.
  - in_ready = 1 in the first cycle after reset releases.
- Stage 1 (accept):
  - On in_valid & in_ready, register per-bit g_i = X_i & ~Y_i, p_i = X_i | ~Y_i and h_i = X_i ^ ~Y_i.
  - Also register sign bits X[W-1] and Y[W-1].
  - Bit-0 generate absorbs carry-in = 1, so g_0' = p_0.
- Stage 2 (prefix + sum):
  - Full prefix over (g, p) with log2(W) levels of black cells.
  - Carries: c_0 = 1, c_{i+1} = G[i:0]. Sum D_i = h_i ^ c_i.
  - bout = ~G[W-1:0]. ovf is computed from the registered signs and D[W-1].
  - All of these are registered into the output stage.
- Latency and throughput:
  - Exactly 2 cycles from the accepting edge to out_valid with no stall.
  - Throughput is 1 result per cycle while out_ready = 1.
- Flow control (each stage advances only when downstream can take it):
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1, combinational from out_ready and the valid flags. There is no path from in_valid to in_ready.
- Stall and handshake rules:
  - While out_valid & ~out_ready, D/bout/ovf hold stable.
  - Once raised, out_valid stays high until the handshake completes.
- Full pipeline: both stages valid and out_ready = 0 forces in_ready = 0. No operand is dropped or duplicated.
- Simultaneous pop and push:
  - With both stages full and out_ready = 1, the output transfers, stage 1 moves to stage 2 and a new operand is accepted, all in the same cycle.
- Bubble stage: s1_valid = 0 with s2 stalled is legal. in_ready = 1 and the operand fills s1.
- Wrap-around: arithmetic is modulo 2^W. The results follow from the bout and ovf definitions above; no saturation.
- Reset mid-operation: all in-flight results are discarded, and out_valid drops asynchronously with rst.
- Datapath registers need no reset; only the valid flags and output registers are reset.

Decomposition:
- Shared package sub_pkg holds:
  - localparam DEFAULT_W = 6
  - typedef gp_t: a struct of two bits, g and p
  - function prefix_levels(W) = $clog2(W)
- Sub-module prefix_black_cell, combinational:
  - (g_hi, p_hi, g_lo, p_lo) -> (g_hi | p_hi & g_lo, p_hi & p_lo)
  - Instantiated in a generate loop for the prefix tree.
- Top-level holds the handshake logic, stage registers and sum/flag logic.

Test Plan:
- Basic (W=6, out_ready=1): X=13, Y=5 -> 2 cycles later D=8, bout=0, ovf=0; X=5, Y=13 -> D=56 (0x38), bout=1, ovf=0.
- Extremes: X=0, Y=0 -> D=0, bout=0; X=63, Y=63 -> D=0, bout=0; X=0, Y=1 -> D=63, bout=1, ovf=0; X=0x20, Y=0x01 -> D=0x1F, bout=0, ovf=1.
- Streaming: 64 back-to-back random pairs with in_valid=1 and out_ready=1 -> one result per cycle, in order, each matching (X-Y) mod 64; in_ready stays 1.
- Backpressure: out_ready=0, push 3 pairs (20-7, 7-20, 31-31) -> first two accepted and in_ready=0 from cycle 3; D=13 held stable. Then out_ready=1 -> outputs 13, 51 (bout=1), 0 in consecutive cycles; no loss.
- Simultaneous: pipeline full with out_ready toggling 1/0/1 each cycle and in_valid held 1 -> accepted count equals delivered count, order preserved.
- Reset mid-op: assert rst with 2 results in flight -> out_valid=0 immediately; after release, in_ready=1, and no stale result ever appears.

Source files
------------

// File: rtl/prefix_subtractor_pipe_pkg.sv
// Shared types and helpers for the prefix subtractor pipeline.
package sub_pkg;
  localparam int DEFAULT_W = 6;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int prefix_levels(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/prefix_subtractor_pipe_if.sv
// Operand/result valid-ready bus for the prefix subtractor.
interface prefix_subtractor_pipe_if
  import sub_pkg::*;
#(
  parameter int W = DEFAULT_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         bout;
  logic         ovf;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, D, bout, ovf
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, D, bout, ovf
  );
endinterface

// File: rtl/prefix_subtractor_pipe_black_cell.sv
// Kogge-Stone black cell: merges a high (g,p) span with the adjacent low span.
module prefix_black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage X - Y subtractor: stage 1 registers g/p/h of X + ~Y + 1,
// stage 2 runs the prefix tree and registers D, borrow and overflow.
module prefix_subtractor_pipe
  import sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input logic                     clk,
  input logic                     rst,
  prefix_subtractor_pipe_if.slave bus
);
  localparam int L = prefix_levels(W);

  logic adv1, adv2;
  logic s1_valid, s2_valid;

  assign adv2         = ~s2_valid | bus.out_ready;
  assign adv1         = ~s1_valid | adv2;
  assign bus.in_ready = adv1;

  // Stage 1: bitwise generate/propagate/half-sum against inverted Y
  logic [W-1:0] y_n;
  gp_t  [W-1:0] in_gp;

  assign y_n = ~bus.Y;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      in_gp[i].g = bus.X[i] & y_n[i];
      in_gp[i].p = bus.X[i] | y_n[i];
    end
    // carry-in of 1 folds into bit 0: it generates whenever it propagates
    in_gp[0].g = in_gp[0].p;
  end

  gp_t  [W-1:0] s1_gp;
  logic [W-1:0] s1_h;
  logic         s1_sx, s1_sy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       s1_valid <= 1'b0;
    else if (adv1) s1_valid <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      s1_gp <= in_gp;
      s1_h  <= bus.X ^ y_n;
      s1_sx <= bus.X[W-1];
      s1_sy <= bus.Y[W-1];
    end
  end

  // Stage 2: log2(W)-level Kogge-Stone prefix tree
  for (genvar l = 0; l < L; l++) begin : lvl
    gp_t [W-1:0] prv;
    gp_t [W-1:0] nxt;
    if (l == 0) begin : g_first
      assign prv = s1_gp;
    end else begin : g_chain
      assign prv = lvl[l-1].nxt;
    end
    for (genvar i = 0; i < W; i++) begin : bit_g
      if (i >= (1 << l)) begin : g_blk
        prefix_black_cell u_cell (
          .g_hi(prv[i].g),
          .p_hi(prv[i].p),
          .g_lo(prv[i-(1<<l)].g),
          .p_lo(prv[i-(1<<l)].p),
          .g   (nxt[i].g),
          .p   (nxt[i].p)
        );
      end else begin : g_pass
        assign nxt[i] = prv[i];
      end
    end
  end

  gp_t  [W-1:0] gp_fin;
  logic [W-1:0] g_pre;
  logic [W-1:0] p_fin;
  logic [W:0]   c;
  logic [W-1:0] d_nx;
  logic         unused_p;

  assign gp_fin = lvl[L-1].nxt;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      g_pre[i] = gp_fin[i].g;
      p_fin[i] = gp_fin[i].p;
    end
  end

  assign unused_p = ^p_fin;
  assign c        = {g_pre, 1'b1};
  assign d_nx     = s1_h ^ c[W-1:0];

  logic [W-1:0] d_q;
  logic         bout_q, ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d_q    <= d_nx;
        bout_q <= ~c[W];
        ovf_q  <= (s1_sx ^ s1_sy) & (d_nx[W-1] ^ s1_sx);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.D         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Scoreboard bench for prefix_subtractor_pipe: accepted operands queue an
// arithmetic reference result; a monitor compares every presented output.
module tb_prefix_subtractor_pipe;
  localparam int W    = 6;
  localparam int MODV = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  prefix_subtractor_pipe_if #(.W(W)) bus ();
  prefix_subtractor_pipe #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, accepted = 0, delivered = 0;

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int r, sx, sy;
    r   = (x - y + MODV) % MODV;
    e.d = W'(r);
    e.b = (x < y);
    sx  = (x >= HALF) ? x - MODV : x;
    sy  = (y >= HALF) ? y - MODV : y;
    r   = sx - sy;
    e.o = (r > HALF - 1) || (r < -HALF);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare before push so an empty-queue output is caught as stale
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("stale_output", 32'(bus.out_valid), 32'd0);
        else begin
          chk("result", 32'({bus.D, bus.bout, bus.ovf}), 32'({q[0].d, q[0].b, q[0].o}));
          if (bus.out_ready) begin
            void'(q.pop_front());
            delivered++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(int'(bus.X), int'(bus.Y)));
        accepted++;
      end
    end
  end

  initial forever begin
    @(posedge rst);
    q.delete();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int x, input int y, output int waits);
    logic acc;
    bus.in_valid = 1'b1;
    bus.X = W'(x);
    bus.Y = W'(y);
    waits = 0;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 200) begin
        chk("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
  endtask

  task automatic drain();
    int t;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  int dx[6] = '{13, 5, 0, 63, 0, 32};
  int dy[6] = '{5, 13, 0, 63, 1, 1};
  int ed[6] = '{8, 56, 0, 0, 63, 31};
  int eb[6] = '{0, 1, 0, 0, 1, 0};
  int eo[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    int w, stalls, a0, d0;
    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'({bus.out_valid, bus.D, bus.bout, bus.ovf, bus.in_ready}),
        32'({1'b0, 6'd0, 1'b0, 1'b0, 1'b1}));
    @(posedge clk);
    #1;

    // directed vectors with latency check
    for (int i = 0; i < 6; i++) begin
      send(dx[i], dy[i], w);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("latency_not_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("directed", 32'({bus.out_valid, bus.D, bus.bout, bus.ovf}),
          32'({1'b1, W'(ed[i]), eb[i][0], eo[i][0]}));
      @(posedge clk);
      #1;
    end

    // streaming at full throughput
    stalls = 0;
    d0 = delivered;
    for (int i = 0; i < 64; i++) begin
      send(int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)), w);
      stalls += w;
    end
    bus.in_valid = 1'b0;
    chk("stream_no_stall", 32'(stalls), 32'd0);
    drain();
    chk("stream_count", 32'(delivered - d0), 32'd64);

    // backpressure: two fit, third blocked
    bus.out_ready = 1'b0;
    send(20, 7, w);
    send(7, 20, w);
    bus.X = W'(31);
    bus.Y = W'(31);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_hold", 32'({bus.out_valid, bus.D, bus.bout}), 32'({1'b1, 6'd13, 1'b0}));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out0", 32'({bus.out_valid, bus.D, bus.bout}), 32'({1'b1, 6'd13, 1'b0}));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out1", 32'({bus.out_valid, bus.D, bus.bout}), 32'({1'b1, 6'd51, 1'b1}));
    @(negedge clk);
    chk("bp_out2", 32'({bus.out_valid, bus.D, bus.bout}), 32'({1'b1, 6'd0, 1'b0}));
    @(posedge clk);
    #1;
    drain();

    // simultaneous push/pop with toggling out_ready
    a0 = accepted;
    d0 = delivered;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 42; i++) begin
      bus.in_valid = 1'b1;
      bus.X = W'($urandom_range(0, MODV - 1));
      bus.Y = W'($urandom_range(0, MODV - 1));
      if (i >= 2) bus.out_ready = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    drain();
    chk("simul_count", 32'(delivered - d0), 32'(accepted - a0));
    chk("simul_progress", 32'((accepted - a0) >= 10), 32'd1);

    // reset with two results in flight
    bus.out_ready = 1'b0;
    send(1, 2, w);
    send(3, 4, w);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rst_async_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    d0 = delivered;
    send(40, 3, w);
    drain();
    chk("post_rst_count", 32'(delivered - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
